// File: rtl/irq_key_event_gen_if.sv
// Bus bundle between the key/interrupt block and whoever drives it.
// The master side drives the key, mask and ack inputs. The slave side (the
// interrupt generator) drives the interrupt vector and the status outputs.
interface irq_key_event_gen_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] key_n;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] irq_ack;
    logic [NUM_CH-1:0] irq_vec_n;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overrun;
    logic [NUM_CH-1:0] key_level;
    logic [15:0]       event_count;

    modport master (
        output key_n,
        output mask,
        output irq_ack,
        input  irq_vec_n,
        input  pending,
        input  overrun,
        input  key_level,
        input  event_count
    );

    modport slave (
        input  key_n,
        input  mask,
        input  irq_ack,
        output irq_vec_n,
        output pending,
        output overrun,
        output key_level,
        output event_count
    );
endinterface

// File: rtl/irq_key_event_gen.sv
// Push-button interrupt source for the HPS active-low input conduit.
// Each raw active-low key is synchronised and debounced. A debounced press
// latches a pending flag, which is driven low-active to the HPS until
// software acknowledges it. The block also keeps a sticky overrun flag per
// channel and a global press counter.
module irq_key_event_gen #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    irq_key_event_gen_if.slave bus
);

    // Terminal count. Once the counter reaches this value with the level
    // still differing, DEBOUNCE_CYCLES consecutive differing samples have
    // been seen.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] sync_meta_q;
    logic [NUM_CH-1:0] sync_q;
    logic [CNT_W-1:0]  db_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] key_level_q;
    logic [NUM_CH-1:0] kl_d_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] overrun_q;
    logic [NUM_CH-1:0] irq_vec_n_q;
    logic [15:0]       event_count_q;

    logic [NUM_CH-1:0] press;
    logic [NUM_CH-1:0] set_req;
    logic [NUM_CH-1:0] pending_next;
    logic [NUM_CH-1:0] overrun_next;
    logic [15:0]       press_cnt;

    // Two-flop synchroniser on the raw keys. Keys idle high (released).
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_meta_q <= '1;
            sync_q      <= '1;
        end else begin
            sync_meta_q <= bus.key_n;
            sync_q      <= sync_meta_q;
        end
    end

    // Per-channel debounce. A new level is accepted only after it has held
    // for DEBOUNCE_CYCLES synchronised samples.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt_q[i] <= '0;
            end
            key_level_q <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_q[i] == key_level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    key_level_q[i] <= sync_q[i];
                    db_cnt_q[i]    <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Delayed copy of the debounced level, used for falling-edge (press) detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            kl_d_q <= '1;
        end else begin
            kl_d_q <= key_level_q;
        end
    end

    // Press events and the next-state terms for pending and overrun.
    // A set in the same cycle as an ack wins, so no press is ever lost.
    always_comb begin
        press        = kl_d_q & ~key_level_q;
        set_req      = press & bus.mask;
        pending_next = set_req | (pending_q & ~bus.irq_ack);
        overrun_next = (set_req & pending_q) | (overrun_q & ~bus.irq_ack);
    end

    // Count the presses in this cycle, masked channels included.
    always_comb begin
        press_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            press_cnt = press_cnt + 16'(press[i]);
        end
    end

    // Interrupt state. The vector gets its own register so the conduit is
    // driven straight from a flop.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pending_q   <= '0;
            overrun_q   <= '0;
            irq_vec_n_q <= '1;
        end else begin
            pending_q   <= pending_next;
            overrun_q   <= overrun_next;
            irq_vec_n_q <= ~pending_next;
        end
    end

    // Global press counter. It wraps naturally modulo 2^16.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            event_count_q <= '0;
        end else begin
            event_count_q <= event_count_q + press_cnt;
        end
    end

    assign bus.irq_vec_n   = irq_vec_n_q;
    assign bus.pending     = pending_q;
    assign bus.overrun     = overrun_q;
    assign bus.key_level   = key_level_q;
    assign bus.event_count = event_count_q;

endmodule

// File: tb/tb_irq_key_event_gen.sv
// Directed bench for irq_key_event_gen with a short debounce window (4 cycles).
// Expected values are worked out by hand from the edge-count latency:
// key_level falls after edge DB+2, and pending is set after edge DB+3.
module tb_irq_key_event_gen;

    localparam int NUM_CH = 4;
    localparam int DB     = 4;
    localparam int CNT_W  = 8;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    irq_key_event_gen_if #(.NUM_CH(NUM_CH)) bus ();

    irq_key_event_gen #(
        .NUM_CH(NUM_CH),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CNT_W)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(reset_n),
        .bus(bus.slave)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then step 1 ns past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] key_n, input logic [3:0] mask,
                                 input logic [3:0] ack);
        bus.key_n   = key_n;
        bus.mask    = mask;
        bus.irq_ack = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        applyStimulus(4'hF, 4'hF, 4'h0);
        tick(2);
        checkOutput("rst_irq_vec_n", 32'(bus.irq_vec_n), 32'hF);
        checkOutput("rst_pending", 32'(bus.pending), 32'h0);
        checkOutput("rst_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("rst_key_level", 32'(bus.key_level), 32'hF);
        checkOutput("rst_count", 32'(bus.event_count), 32'h0);
        reset_n = 1'b1;
        tick(3);

        // Basic press latency on key 0.
        applyStimulus(4'b1110, 4'hF, 4'h0);
        tick(5);
        checkOutput("t1_kl_edge5", 32'(bus.key_level), 32'hF);
        tick(1);
        checkOutput("t1_kl_edge6", 32'(bus.key_level), 32'hE);
        checkOutput("t1_pend_edge6", 32'(bus.pending), 32'h0);
        tick(1);
        checkOutput("t1_pend_edge7", 32'(bus.pending), 32'h1);
        checkOutput("t1_vec_edge7", 32'(bus.irq_vec_n), 32'hE);
        checkOutput("t1_count", 32'(bus.event_count), 32'h1);

        // A glitch on key 1 that is too short to be accepted.
        applyStimulus(4'b1100, 4'hF, 4'h0);
        tick(3);
        applyStimulus(4'b1110, 4'hF, 4'h0);
        tick(10);
        checkOutput("t2_glitch_kl", 32'(bus.key_level), 32'hE);
        checkOutput("t2_glitch_pend", 32'(bus.pending), 32'h1);
        checkOutput("t2_glitch_count", 32'(bus.event_count), 32'h1);
        // Releasing key 0 must not create an event.
        applyStimulus(4'hF, 4'hF, 4'h0);
        tick(10);
        checkOutput("t2_rel_kl", 32'(bus.key_level), 32'hF);
        checkOutput("t2_rel_count", 32'(bus.event_count), 32'h1);
        checkOutput("t2_rel_pend", 32'(bus.pending), 32'h1);

        // An ack clears pending on the next edge.
        applyStimulus(4'hF, 4'hF, 4'b0001);
        tick(1);
        applyStimulus(4'hF, 4'hF, 4'h0);
        checkOutput("t3_ack_pend", 32'(bus.pending), 32'h0);
        checkOutput("t3_ack_vec", 32'(bus.irq_vec_n), 32'hF);
        // Press twice without an ack, which gives an overrun.
        applyStimulus(4'b1110, 4'hF, 4'h0);
        tick(7);
        checkOutput("t3_p1_pend", 32'(bus.pending), 32'h1);
        checkOutput("t3_p1_ovr", 32'(bus.overrun), 32'h0);
        applyStimulus(4'hF, 4'hF, 4'h0);
        tick(10);
        applyStimulus(4'b1110, 4'hF, 4'h0);
        tick(7);
        checkOutput("t3_p2_ovr", 32'(bus.overrun), 32'h1);
        checkOutput("t3_p2_count", 32'(bus.event_count), 32'h3);
        applyStimulus(4'b1110, 4'hF, 4'b0001);
        tick(1);
        applyStimulus(4'b1110, 4'hF, 4'h0);
        checkOutput("t3_ack2_pend", 32'(bus.pending), 32'h0);
        checkOutput("t3_ack2_ovr", 32'(bus.overrun), 32'h0);
        applyStimulus(4'hF, 4'hF, 4'h0);
        tick(10);
        // A press whose set edge coincides with an ack, where the set wins.
        applyStimulus(4'b1110, 4'hF, 4'h0);
        tick(6);
        applyStimulus(4'b1110, 4'hF, 4'b0001);
        tick(1);
        applyStimulus(4'b1110, 4'hF, 4'h0);
        checkOutput("t3_coinc_pend", 32'(bus.pending), 32'h1);
        checkOutput("t3_coinc_ovr", 32'(bus.overrun), 32'h0);
        checkOutput("t3_coinc_count", 32'(bus.event_count), 32'h4);
        applyStimulus(4'hF, 4'hF, 4'b0001);
        tick(1);
        applyStimulus(4'hF, 4'hF, 4'h0);
        tick(10);

        // A masked channel still counts, but does not raise an interrupt.
        applyStimulus(4'b1011, 4'b1011, 4'h0);
        tick(7);
        checkOutput("t4_mask_pend", 32'(bus.pending), 32'h0);
        checkOutput("t4_mask_vec", 32'(bus.irq_vec_n), 32'hF);
        checkOutput("t4_mask_count", 32'(bus.event_count), 32'h5);
        applyStimulus(4'hF, 4'hF, 4'h0);
        tick(10);
        // Simultaneous presses on keys 0 and 3.
        applyStimulus(4'b0110, 4'hF, 4'h0);
        tick(7);
        checkOutput("t4_sim_pend", 32'(bus.pending), 32'h9);
        checkOutput("t4_sim_count", 32'(bus.event_count), 32'h7);
        applyStimulus(4'hF, 4'hF, 4'b1001);
        tick(1);
        applyStimulus(4'hF, 4'hF, 4'h0);
        tick(10);

        // Reset mid-operation: pending is 0101 and key 1 is mid-debounce.
        applyStimulus(4'b1010, 4'hF, 4'h0);
        tick(7);
        checkOutput("t5_pre_pend", 32'(bus.pending), 32'h5);
        checkOutput("t5_pre_count", 32'(bus.event_count), 32'h9);
        applyStimulus(4'b1000, 4'hF, 4'h0);
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_pend", 32'(bus.pending), 32'h0);
        checkOutput("t5_rst_vec", 32'(bus.irq_vec_n), 32'hF);
        checkOutput("t5_rst_kl", 32'(bus.key_level), 32'hF);
        checkOutput("t5_rst_count", 32'(bus.event_count), 32'h0);
        tick(3);
        reset_n = 1'b1;
        tick(DB + 1);
        checkOutput("t5_post_kl_early", 32'(bus.key_level), 32'hF);
        tick(1);
        checkOutput("t5_post_kl", 32'(bus.key_level), 32'h8);
        checkOutput("t5_post_pend_early", 32'(bus.pending), 32'h0);
        tick(1);
        checkOutput("t5_post_pend", 32'(bus.pending), 32'h7);
        checkOutput("t5_post_count", 32'(bus.event_count), 32'h3);
        applyStimulus(4'hF, 4'hF, 4'hF);
        tick(1);
        applyStimulus(4'hF, 4'hF, 4'h0);
        tick(10);

        // Counter wrap, with the count preloaded to 0xFFFF.
        force dut.event_count_q = 16'hFFFF;
        tick(1);
        release dut.event_count_q;
        tick(1);
        checkOutput("t6_preload", 32'(bus.event_count), 32'hFFFF);
        applyStimulus(4'b0111, 4'hF, 4'h0);
        tick(7);
        checkOutput("t6_wrap", 32'(bus.event_count), 32'h0);
        checkOutput("t6_pend", 32'(bus.pending), 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
